// File: rtl/doctor_allot_scheduler.sv
// Reception scheduler: allots patients to two doctors with fixed consultation timers
// and parks overflow arrivals in a ticketed FIFO that freed doctors drain.
module doctor_allot_scheduler #(
  parameter int CONSULT_CYCLES = 15,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TICKET_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   query,
  output logic [1:0]                   message,
  output logic                         msg_valid,
  output logic [TICKET_W-1:0]          ticket_out,
  output logic                         reject,
  output logic                         busy_a,
  output logic                         busy_b,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(CONSULT_CYCLES + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(CONSULT_CYCLES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [CW-1:0] Q_FULL = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    MSG_NONE = 2'd0,
    MSG_DOC1 = 2'd1,
    MSG_DOC2 = 2'd2,
    MSG_WAIT = 2'd3
  } msg_e;

  logic [TW-1:0]       timer_a_reg, timer_b_reg;
  logic                busy_a_reg, busy_b_reg;
  logic [PW-1:0]       head_reg, tail_reg;
  logic [CW-1:0]       count_reg;
  logic [TICKET_W-1:0] next_ticket_reg;
  logic                rr_b_reg;
  msg_e                message_reg;
  logic                msg_valid_reg;
  logic [TICKET_W-1:0] ticket_out_reg;
  logic                reject_reg;
  logic [TICKET_W-1:0] queue_mem [QUEUE_DEPTH];

  logic new_pt, early_a, early_b, status_q;
  logic q_ne, q_full;
  logic rel_a, rel_b, pop_a, pop_b, defer_b, do_pop;
  logic alloc_a, alloc_b, push, rej;
  logic [TICKET_W-1:0] head_ticket;

  always_comb begin
    new_pt   = start && (query == 2'b00);
    early_a  = start && (query == 2'b01);
    early_b  = start && (query == 2'b10);
    status_q = start && (query == 2'b11);
    q_ne     = (count_reg != '0);
    q_full   = (count_reg == Q_FULL);
    // A timer held at 0 with busy set is a doctor 2 release deferred from last cycle.
    rel_a    = busy_a_reg && ((timer_a_reg <= T_ONE) || early_a);
    rel_b    = busy_b_reg && ((timer_b_reg <= T_ONE) || early_b);
    pop_a    = rel_a && q_ne;
    pop_b    = rel_b && q_ne && !pop_a;
    defer_b  = rel_b && q_ne && pop_a;
    do_pop   = pop_a || pop_b;
    // Direct allotment only happens with an empty queue, so a releasing doctor is free.
    alloc_a  = new_pt && !q_ne && (!busy_a_reg || rel_a) &&
               (!rr_b_reg || (busy_b_reg && !rel_b));
    alloc_b  = new_pt && !q_ne && (!busy_b_reg || rel_b) && !alloc_a;
    push     = new_pt && !alloc_a && !alloc_b && (do_pop || !q_full);
    rej      = new_pt && !alloc_a && !alloc_b && !do_pop && q_full;
    head_ticket = queue_mem[head_reg];
  end

  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (push && (tail_reg == PW'(gi))) begin
          queue_mem[gi] <= next_ticket_reg;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_a_reg     <= '0;
      timer_b_reg     <= '0;
      busy_a_reg      <= 1'b0;
      busy_b_reg      <= 1'b0;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      next_ticket_reg <= '0;
      rr_b_reg        <= 1'b0;
      message_reg     <= MSG_NONE;
      msg_valid_reg   <= 1'b0;
      ticket_out_reg  <= '0;
      reject_reg      <= 1'b0;
    end else begin
      msg_valid_reg <= 1'b0;
      reject_reg    <= 1'b0;

      if (pop_a || alloc_a) begin
        busy_a_reg  <= 1'b1;
        timer_a_reg <= T_LOAD;
      end else if (rel_a) begin
        busy_a_reg  <= 1'b0;
        timer_a_reg <= '0;
      end else if (busy_a_reg) begin
        timer_a_reg <= timer_a_reg - T_ONE;
      end

      if (pop_b || alloc_b) begin
        busy_b_reg  <= 1'b1;
        timer_b_reg <= T_LOAD;
      end else if (defer_b) begin
        timer_b_reg <= '0;
      end else if (rel_b) begin
        busy_b_reg  <= 1'b0;
        timer_b_reg <= '0;
      end else if (busy_b_reg) begin
        timer_b_reg <= timer_b_reg - T_ONE;
      end

      if (push) tail_reg <= tail_reg + PW'(1);
      if (do_pop) head_reg <= head_reg + PW'(1);
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase

      if (new_pt) next_ticket_reg <= next_ticket_reg + TICKET_W'(1);

      if (pop_a || alloc_a) rr_b_reg <= 1'b1;
      else if (pop_b || alloc_b) rr_b_reg <= 1'b0;

      // A pop owns the message slot; a coinciding arrival is queued silently.
      if (do_pop) begin
        message_reg    <= pop_a ? MSG_DOC1 : MSG_DOC2;
        ticket_out_reg <= head_ticket;
        msg_valid_reg  <= 1'b1;
      end else if (alloc_a || alloc_b) begin
        message_reg    <= alloc_a ? MSG_DOC1 : MSG_DOC2;
        ticket_out_reg <= next_ticket_reg;
        msg_valid_reg  <= 1'b1;
      end else if (push) begin
        message_reg    <= MSG_WAIT;
        ticket_out_reg <= next_ticket_reg;
        msg_valid_reg  <= 1'b1;
      end else if (rej) begin
        message_reg    <= MSG_NONE;
        ticket_out_reg <= next_ticket_reg;
        msg_valid_reg  <= 1'b1;
        reject_reg     <= 1'b1;
      end else if (status_q) begin
        message_reg    <= (busy_a_reg && busy_b_reg) ? MSG_WAIT : MSG_NONE;
        msg_valid_reg  <= 1'b1;
      end
    end
  end

  assign message     = message_reg;
  assign msg_valid   = msg_valid_reg;
  assign ticket_out  = ticket_out_reg;
  assign reject      = reject_reg;
  assign busy_a      = busy_a_reg;
  assign busy_b      = busy_b_reg;
  assign queue_count = count_reg;

endmodule

// File: tb/tb_doctor_allot_scheduler.sv
// Directed bench for doctor_allot_scheduler with CONSULT_CYCLES=15, QUEUE_DEPTH=4.
module tb_doctor_allot_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] query = 2'b00;
  logic [1:0] message;
  logic       msg_valid;
  logic [3:0] ticket_out;
  logic       reject;
  logic       busy_a;
  logic       busy_b;
  logic [2:0] queue_count;

  int vectors = 0;
  int errors  = 0;

  doctor_allot_scheduler #(
    .CONSULT_CYCLES(15),
    .QUEUE_DEPTH(4),
    .TICKET_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .query(query),
    .message(message),
    .msg_valid(msg_valid),
    .ticket_out(ticket_out),
    .reject(reject),
    .busy_a(busy_a),
    .busy_b(busy_b),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  // One clock edge per call; outputs are sampled on the following falling edge.
  task automatic step(input logic s, input logic [1:0] q);
    start = s;
    query = q;
    @(negedge clk);
    start = 1'b0;
    query = 2'b00;
    if (s)
      $display("t=%0t query=%0d -> msg=%0d valid=%0b ticket=%0d rej=%0b busy=%0b%0b qc=%0d",
               $time, q, message, msg_valid, ticket_out, reject, busy_a, busy_b, queue_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 2'b00);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 2'b00);
    do_reset();
    vectors++; if (message !== 2'd0) begin errors++; $display("FAIL reset_msg: got %0d want 0", message); end
    vectors++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", msg_valid); end
    vectors++; if (ticket_out !== 4'd0) begin errors++; $display("FAIL reset_ticket: got %0d want 0", ticket_out); end
    vectors++; if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %0b want 0", reject); end
    vectors++; if ({busy_a, busy_b} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %0b%0b want 00", busy_a, busy_b); end
    vectors++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_qc: got %0d want 0", queue_count); end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 2'b00);
    vectors++; if (message !== 2'd1) begin errors++; $display("FAIL single_msg: got %0d want 1", message); end
    vectors++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", msg_valid); end
    vectors++; if (ticket_out !== 4'd0) begin errors++; $display("FAIL single_ticket: got %0d want 0", ticket_out); end
    vectors++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_start: got %0b want 1", busy_a); end
    idle(14);
    vectors++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %0b want 1", busy_a); end
    vectors++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %0b want 0", msg_valid); end
    idle(1);
    vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %0b want 0", busy_a); end
    step(1'b1, 2'b00);
    vectors++; if (message !== 2'd2) begin errors++; $display("FAIL single_rr_msg: got %0d want 2", message); end
    vectors++; if (ticket_out !== 4'd1) begin errors++; $display("FAIL single_rr_ticket: got %0d want 1", ticket_out); end
  endtask

  task automatic test_three();
    do_reset();
    step(1'b1, 2'b00);
    vectors++; if (message !== 2'd1) begin errors++; $display("FAIL three_msg0: got %0d want 1", message); end
    step(1'b1, 2'b00);
    vectors++; if (message !== 2'd2) begin errors++; $display("FAIL three_msg1: got %0d want 2", message); end
    vectors++; if (ticket_out !== 4'd1) begin errors++; $display("FAIL three_ticket1: got %0d want 1", ticket_out); end
    step(1'b1, 2'b00);
    vectors++; if (message !== 2'd3) begin errors++; $display("FAIL three_msg2: got %0d want 3", message); end
    vectors++; if (ticket_out !== 4'd2) begin errors++; $display("FAIL three_ticket2: got %0d want 2", ticket_out); end
    vectors++; if (queue_count !== 3'd1) begin errors++; $display("FAIL three_qc: got %0d want 1", queue_count); end
    idle(12);
    vectors++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL three_quiet: got %0b want 0", msg_valid); end
    idle(1);
    vectors++; if ({msg_valid, message} !== 3'b1_01) begin errors++; $display("FAIL three_pop_msg: got v%0b m%0d want v1 m1", msg_valid, message); end
    vectors++; if (ticket_out !== 4'd2) begin errors++; $display("FAIL three_pop_ticket: got %0d want 2", ticket_out); end
    vectors++; if (busy_a !== 1'b1) begin errors++; $display("FAIL three_no_gap: got %0b want 1", busy_a); end
    vectors++; if (queue_count !== 3'd0) begin errors++; $display("FAIL three_pop_qc: got %0d want 0", queue_count); end
    idle(1);
    vectors++; if ({busy_b, msg_valid} !== 2'b00) begin errors++; $display("FAIL three_b_free: got busy_b=%0b valid=%0b want 0 0", busy_b, msg_valid); end
  endtask

  task automatic test_queue_full();
    do_reset();
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b00);
      vectors++; if ({message, ticket_out} !== {2'd3, 4'(i + 2)}) begin errors++; $display("FAIL full_push%0d: got m%0d t%0d want m3 t%0d", i, message, ticket_out, i + 2); end
      vectors++; if (queue_count !== 3'(i + 1)) begin errors++; $display("FAIL full_qc%0d: got %0d want %0d", i, queue_count, i + 1); end
    end
    step(1'b1, 2'b00);
    vectors++; if ({reject, msg_valid, message} !== 4'b1_1_00) begin errors++; $display("FAIL full_reject: got r%0b v%0b m%0d want r1 v1 m0", reject, msg_valid, message); end
    vectors++; if (queue_count !== 3'd4) begin errors++; $display("FAIL full_reject_qc: got %0d want 4", queue_count); end
    step(1'b1, 2'b00);
    vectors++; if ({reject, ticket_out} !== {1'b1, 4'd7}) begin errors++; $display("FAIL full_next_ticket: got r%0b t%0d want r1 t7", reject, ticket_out); end
    idle(7);
    vectors++; if (reject !== 1'b0) begin errors++; $display("FAIL full_reject_pulse: got %0b want 0", reject); end
    step(1'b1, 2'b00);
    vectors++; if ({message, ticket_out} !== {2'd1, 4'd2}) begin errors++; $display("FAIL full_pushpop_msg: got m%0d t%0d want m1 t2", message, ticket_out); end
    vectors++; if ({reject, queue_count} !== {1'b0, 3'd4}) begin errors++; $display("FAIL full_pushpop_qc: got r%0b qc%0d want r0 qc4", reject, queue_count); end
    idle(1);
    vectors++; if ({message, ticket_out, queue_count} !== {2'd2, 4'd3, 3'd3}) begin errors++; $display("FAIL full_b_pop: got m%0d t%0d qc%0d want m2 t3 qc3", message, ticket_out, queue_count); end
    idle(14);
    vectors++; if ({message, ticket_out} !== {2'd1, 4'd4}) begin errors++; $display("FAIL full_a_pop2: got m%0d t%0d want m1 t4", message, ticket_out); end
    idle(1);
    vectors++; if ({message, ticket_out, queue_count} !== {2'd2, 4'd5, 3'd1}) begin errors++; $display("FAIL full_b_pop2: got m%0d t%0d qc%0d want m2 t5 qc1", message, ticket_out, queue_count); end
    idle(14);
    vectors++; if ({message, ticket_out, queue_count} !== {2'd1, 4'd8, 3'd0}) begin errors++; $display("FAIL full_wrap_pop: got m%0d t%0d qc%0d want m1 t8 qc0", message, ticket_out, queue_count); end
  endtask

  task automatic test_early();
    do_reset();
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    idle(1);
    step(1'b1, 2'b01);
    vectors++; if ({msg_valid, message, ticket_out} !== {1'b1, 2'd1, 4'd2}) begin errors++; $display("FAIL early_a_pop: got v%0b m%0d t%0d want v1 m1 t2", msg_valid, message, ticket_out); end
    vectors++; if ({busy_a, queue_count} !== {1'b1, 3'd0}) begin errors++; $display("FAIL early_a_state: got busy_a=%0b qc%0d want 1 0", busy_a, queue_count); end
    step(1'b1, 2'b10);
    vectors++; if ({busy_b, msg_valid} !== 2'b00) begin errors++; $display("FAIL early_b_free: got busy_b=%0b valid=%0b want 0 0", busy_b, msg_valid); end
    step(1'b1, 2'b10);
    vectors++; if ({busy_a, busy_b, msg_valid, queue_count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin errors++; $display("FAIL early_b_idle: got a%0b b%0b v%0b qc%0d want a1 b0 v0 qc0", busy_a, busy_b, msg_valid, queue_count); end
    step(1'b1, 2'b11);
    vectors++; if ({msg_valid, message} !== 3'b1_00) begin errors++; $display("FAIL status_free: got v%0b m%0d want v1 m0", msg_valid, message); end
    step(1'b1, 2'b00);
    vectors++; if ({message, ticket_out} !== {2'd2, 4'd3}) begin errors++; $display("FAIL early_only_b: got m%0d t%0d want m2 t3", message, ticket_out); end
    step(1'b1, 2'b11);
    vectors++; if ({msg_valid, message, ticket_out} !== {1'b1, 2'd3, 4'd3}) begin errors++; $display("FAIL status_busy: got v%0b m%0d t%0d want v1 m3 t3", msg_valid, message, ticket_out); end
  endtask

  task automatic test_both_expire();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'b00);
    vectors++; if (queue_count !== 3'd2) begin errors++; $display("FAIL both_qc: got %0d want 2", queue_count); end
    idle(11);
    step(1'b1, 2'b10);
    vectors++; if ({message, ticket_out} !== {2'd1, 4'd2}) begin errors++; $display("FAIL both_first: got m%0d t%0d want m1 t2", message, ticket_out); end
    vectors++; if ({busy_b, queue_count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL both_defer: got busy_b=%0b qc%0d want 1 1", busy_b, queue_count); end
    idle(1);
    vectors++; if ({msg_valid, message, ticket_out} !== {1'b1, 2'd2, 4'd3}) begin errors++; $display("FAIL both_second: got v%0b m%0d t%0d want v1 m2 t3", msg_valid, message, ticket_out); end
    vectors++; if ({busy_b, queue_count} !== {1'b1, 3'd0}) begin errors++; $display("FAIL both_second_state: got busy_b=%0b qc%0d want 1 0", busy_b, queue_count); end
    idle(13);
    vectors++; if (busy_a !== 1'b1) begin errors++; $display("FAIL both_a_hold: got %0b want 1", busy_a); end
    idle(1);
    vectors++; if ({busy_a, busy_b} !== 2'b01) begin errors++; $display("FAIL both_a_end: got %0b%0b want 01", busy_a, busy_b); end
    idle(1);
    vectors++; if (busy_b !== 1'b0) begin errors++; $display("FAIL both_b_end: got %0b want 0", busy_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00);
    vectors++; if (queue_count !== 3'd3) begin errors++; $display("FAIL mid_qc: got %0d want 3", queue_count); end
    do_reset();
    vectors++; if ({busy_a, busy_b, queue_count, message, msg_valid} !== {1'b0, 1'b0, 3'd0, 2'd0, 1'b0}) begin errors++; $display("FAIL mid_reset: got a%0b b%0b qc%0d m%0d v%0b want all 0", busy_a, busy_b, queue_count, message, msg_valid); end
    step(1'b1, 2'b00);
    vectors++; if ({message, ticket_out, busy_a, busy_b} !== {2'd1, 4'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL mid_after: got m%0d t%0d a%0b b%0b want m1 t0 a1 b0", message, ticket_out, busy_a, busy_b); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_three();
    test_queue_full();
    test_early();
    test_both_expire();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
